// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the program-counter fetch block: widths, FSM
// states, and the branch/jump target table.
package pc_fetch_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 4;
  localparam int LUT_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Indices with no entry read back as target 0.
  localparam int unsigned BR_TABLE [0:LUT_DEPTH-1] = '{
    100, 200, 12, 40, 20, 300, 333, 512,
    640, 700, 777, 850, 900, 1000, 1022, 1023
  };

endpackage

// File: rtl/pc_fetch_lut.sv
// Combinational branch/jump target lookup from the package table.
module pc_lut
  import pc_fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [PC_W-1:0]   target
);

  always_comb begin
    target = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (int'(lut_idx) == i) target = PC_W'(BR_TABLE[i]);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter sequencer: IDLE/RUN/HALT control with jump, flag-based
// branch, stall and a registered ALU flag.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump,
  input  logic              branch,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              flag_we,
  input  logic              alu_flag,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              fetch_valid,
  output logic              flag_q,
  output logic              done
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] target;

  pc_lut #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_lut (
    .lut_idx (lut_idx),
    .target  (target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = ST_RUN;
          flag_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          // Branch decision reads the old flag; the new one lands at this edge.
          if (flag_we) flag_d = alu_flag;
          if (halt)                  state_d = ST_HALT;
          else if (jump)             pc_d = target;
          else if (branch && flag_q) pc_d = target;
          else                       pc_d = pc_q + PC_W'(1);
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          flag_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        flag_d  = 1'b0;
      end
    endcase
    fetch_valid_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      flag_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flag_q        <= flag_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_W, default 10, program-counter width in bits.
REQ-002 Parameter LUT_AW, default 4, branch-target table index width (2^LUT_AW entries).
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin program execution, one-cycle pulse.
REQ-006 stall  input  1  freeze all pc_fetch state for this cycle.
REQ-007 halt  input  1  decoded halt instruction at current prog_ctr.
REQ-008 jump  input  1  decoded unconditional jump.
REQ-009 branch  input  1  decoded conditional branch, taken when flag_q=1.
REQ-010 lut_idx  input  LUT_AW  branch/jump target table index.
REQ-011 flag_we  input  1  capture alu_flag this cycle (cmp/sub/shift instructions).
REQ-012 alu_flag  input  1  combinational flag output of the ALU.
REQ-013 prog_ctr  output  PC_W  address of instruction being fetched.
REQ-014 fetch_valid  output  1  prog_ctr holds a live instruction address.
REQ-015 flag_q  output  1  registered ALU flag used for branches.
REQ-016 done  output  1  program halted, held until next start.

Function
REQ-017 FSM states SHALL be IDLE, RUN, HALT; fetch_valid=1 only in RUN; done=1 only in HALT.
REQ-018 IDLE: start=1 -> RUN next edge with prog_ctr=0; start=0 -> stay IDLE, prog_ctr=0.
REQ-019 RUN, stall=1: prog_ctr, flag_q, and state SHALL all hold; all other inputs ignored.
REQ-020 RUN, stall=0: priority halt > jump > branch-taken > increment.
REQ-021 halt=1 -> HALT next edge, prog_ctr holds its current value.
REQ-022 jump=1 -> prog_ctr = table[lut_idx] next edge.
REQ-023 branch=1 and flag_q=1 -> prog_ctr = table[lut_idx]; branch=1 and flag_q=0 -> prog_ctr+1.
REQ-024 Increment SHALL be modulo 2^PC_W (2^PC_W-1 wraps to 0), no error flag.
REQ-025 flag_we=1 and stall=0 in RUN -> flag_q = alu_flag at the edge.
REQ-026 Flag capture SHALL have no bypass: a branch in the same cycle as flag_we uses the old flag_q.
REQ-027 Outside RUN flag_we SHALL be ignored; flag_q holds.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 HALT + start -> RUN next edge, prog_ctr=0, done=0, flag_q cleared to 0.
REQ-030 prog_ctr, flag_q, fetch_valid, and done SHALL be registered outputs (latency one edge from decision inputs).

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, prog_ctr=0, flag_q=0, fetch_valid=0, done=0, regardless of clk.
REQ-032 Reset asserted mid-RUN or mid-HALT SHALL abandon the program; the first edge after release evaluates IDLE rules.

Structure
REQ-033 The shared package SHALL hold PC_W/LUT_AW defaults, the FSM state enum, and the branch-target table constant.
REQ-034 The target table SHALL be a combinational sub-module pc_lut (lut_idx in, PC_W target out) reading the package constant.
REQ-035 All registers SHALL live in pc_fetch; pc_lut holds no state.

Verification
REQ-036 Reset, then start pulse, 5 idle cycles -> prog_ctr 0,1,2,3,4; fetch_valid=1 from the first RUN cycle.
REQ-037 table[3]=40; at prog_ctr=7 flag_we=1, alu_flag=1, branch=1, lut_idx=3 -> prog_ctr=8 (old flag); branch repeated at pc=8 -> prog_ctr=40.
REQ-038 jump=1 and halt=1 together at prog_ctr=12 -> HALT, prog_ctr=12, done=1; start -> prog_ctr=0, done=0, flag_q=0.
REQ-039 Force prog_ctr=1023 (PC_W=10), no control inputs -> next prog_ctr=0, fetch_valid stays 1.
REQ-040 stall=1 for 3 cycles with jump=1 and flag_we=1 -> prog_ctr and flag_q unchanged throughout.
REQ-041 rst_n pulsed low between edges mid-RUN at prog_ctr=20 -> outputs zero before next edge; state IDLE after release.
